// File: rtl/rv32i_types.sv
// Shared types for the control-flow buffer scheduler.
package rv32i_types;

   typedef enum logic [1:0] {
      CF_RUN   = 2'd0,
      CF_FLUSH = 2'd1,
      CF_HOLD  = 2'd2
   } cf_state_t;

   localparam int CF_BUF_DEPTH = 16;

endpackage

// File: rtl/cf_buffer_sched_if.sv
// Fetch/commit/control-buffer signal bundle around the control-flow scheduler.
interface cf_buffer_sched_if #(
   parameter int DATA_WIDTH = 32
);
   // Handshakes: a transfer happens on a clock edge where valid && ready are both 1;
   // ready may depend on valid, and the requester holds valid and data until accepted.
   logic                  pred_valid;
   logic [DATA_WIDTH-1:0] pred_pc;
   logic                  pred_ready;
   logic                  br_valid;
   logic [DATA_WIDTH-1:0] br_actual_pc;
   logic                  br_ready;
   logic                  buf_enqueue;
   logic [DATA_WIDTH-1:0] buf_wdata;
   logic                  buf_dequeue;
   logic [DATA_WIDTH-1:0] buf_head;
   logic                  buf_full;
   logic                  buf_empty;
   logic                  buf_clear;
   logic                  flush;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;

   modport master (
      output pred_valid, pred_pc, br_valid, br_actual_pc,
      output buf_head, buf_full, buf_empty,
      input  pred_ready, br_ready, buf_enqueue, buf_wdata, buf_dequeue,
      input  buf_clear, flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  pred_valid, pred_pc, br_valid, br_actual_pc,
      input  buf_head, buf_full, buf_empty,
      output pred_ready, br_ready, buf_enqueue, buf_wdata, buf_dequeue,
      output buf_clear, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/cf_buffer_sched.sv
// Push/pop sequencing for the predicted-next-PC buffer with flush/redirect on mispredict.
module cf_buffer_sched
   import rv32i_types::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FLUSH_HOLD = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   cf_buffer_sched_if.slave     bus,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] mispred_count,
   output cf_state_t            cf_state
);

   localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0);
   localparam logic HAS_HOLD = (FLUSH_HOLD > 0);

   cf_state_t             state, next_state;
   logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
   logic                  pulse_q;
   logic [DATA_WIDTH-1:0] redirect_q;
   logic                  pop, mis, push;

   // A mispredict blocks the same-cycle push so nothing lands in a buffer about to be cleared.
   always_comb begin
      pop  = bus.br_valid && bus.br_ready;
      mis  = pop && (bus.buf_head != bus.br_actual_pc);
      push = bus.pred_valid && bus.pred_ready;
   end

   assign bus.br_ready       = (state == CF_RUN) && !bus.buf_empty;
   assign bus.pred_ready     = (state == CF_RUN) && !bus.buf_full && !mis;
   assign bus.buf_enqueue    = push;
   assign bus.buf_wdata      = bus.pred_pc;
   assign bus.buf_dequeue    = pop;
   assign bus.flush          = pulse_q;
   assign bus.redirect_valid = pulse_q;
   assign bus.buf_clear      = pulse_q;
   assign bus.redirect_pc    = redirect_q;
   assign cf_state           = state;

   always_comb begin
      next_state = state;
      hold_nxt   = hold_cnt;
      case (state)
         CF_RUN: begin
            if (mis) next_state = CF_FLUSH;
         end
         CF_FLUSH: begin
            if (HAS_HOLD) begin
               next_state = CF_HOLD;
               hold_nxt   = HOLD_LOAD;
            end else begin
               next_state = CF_RUN;
            end
         end
         CF_HOLD: begin
            if (hold_cnt == '0) next_state = CF_RUN;
            else                hold_nxt   = hold_cnt - HOLD_W'(1);
         end
         default: next_state = CF_RUN;
      endcase
   end

   // Pulses are registered from the next state so they line up with the FLUSH cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= CF_RUN;
         hold_cnt      <= '0;
         pulse_q       <= 1'b0;
         redirect_q    <= '0;
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         state    <= next_state;
         hold_cnt <= hold_nxt;
         pulse_q  <= (next_state == CF_FLUSH);
         if (mis) begin
            redirect_q    <= bus.br_actual_pc;
            mispred_count <= mispred_count + CNT_WIDTH'(1);
         end
         if (pop) br_count <= br_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_cf_buffer_sched.sv
// Bench for cf_buffer_sched: directed plan plus random traffic against a queue-level model.
module tb_cf_buffer_sched;
   import rv32i_types::*;

   localparam int FH0   = 2;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cf_buffer_sched_if #(.DATA_WIDTH(32)) bus0 ();
   cf_buffer_sched_if #(.DATA_WIDTH(32)) bus1 ();
   logic [31:0] brc0, mc0, brc1, mc1;
   cf_state_t   st0, st1;

   cf_buffer_sched #(.DATA_WIDTH(32), .FLUSH_HOLD(FH0), .CNT_WIDTH(32)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .br_count(brc0), .mispred_count(mc0), .cf_state(st0));
   cf_buffer_sched #(.DATA_WIDTH(32), .FLUSH_HOLD(0), .CNT_WIDTH(32)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .br_count(brc1), .mispred_count(mc1), .cf_state(st1));

   // Control buffers: 16-entry FIFOs reset by ~rst | buf_clear.
   logic [31:0] bq0[$];
   logic [31:0] bq1[$];
   always @(posedge clk) begin
      if (!rst || bus0.buf_clear) bq0.delete();
      else begin
         if (bus0.buf_dequeue && bq0.size() > 0) void'(bq0.pop_front());
         if (bus0.buf_enqueue && bq0.size() < DEPTH) bq0.push_back(bus0.buf_wdata);
      end
      bus0.buf_head  <= (bq0.size() > 0) ? bq0[0] : 32'h0;
      bus0.buf_full  <= (bq0.size() == DEPTH);
      bus0.buf_empty <= (bq0.size() == 0);
   end
   always @(posedge clk) begin
      if (!rst || bus1.buf_clear) bq1.delete();
      else begin
         if (bus1.buf_dequeue && bq1.size() > 0) void'(bq1.pop_front());
         if (bus1.buf_enqueue && bq1.size() < DEPTH) bq1.push_back(bus1.buf_wdata);
      end
      bus1.buf_head  <= (bq1.size() > 0) ? bq1[0] : 32'h0;
      bus1.buf_full  <= (bq1.size() == DEPTH);
      bus1.buf_empty <= (bq1.size() == 0);
   end

   // Reference model: expected contents, remaining stall cycles, stats.
   logic [31:0] exp_q[$];
   int          busy;
   logic [31:0] m_br, m_mis, m_rpc;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      busy  = 0;
      m_br  = 0;
      m_mis = 0;
      m_rpc = 0;
   endtask

   task automatic step(input logic pv, input logic [31:0] ppc, input logic bv, input logic [31:0] bpc);
      logic run, first, pop_ok, mis, push_ok;
      cf_state_t exp_st;
      @(negedge clk);
      rst               = 1'b1;
      bus0.pred_valid   = pv;
      bus0.pred_pc      = ppc;
      bus0.br_valid     = bv;
      bus0.br_actual_pc = bpc;
      #1;
      run     = (busy == 0);
      first   = (busy == FH0 + 1);
      pop_ok  = run && bv && (exp_q.size() > 0);
      mis     = pop_ok && (exp_q[0] != bpc);
      push_ok = run && pv && (exp_q.size() < DEPTH) && !mis;
      exp_st  = first ? CF_FLUSH : (run ? CF_RUN : CF_HOLD);
      check("pred_ready", {31'b0, bus0.pred_ready}, {31'b0, run && exp_q.size() < DEPTH && !mis});
      check("br_ready", {31'b0, bus0.br_ready}, {31'b0, run && exp_q.size() > 0});
      check("buf_enqueue", {31'b0, bus0.buf_enqueue}, {31'b0, push_ok});
      check("buf_dequeue", {31'b0, bus0.buf_dequeue}, {31'b0, pop_ok});
      check("flush", {31'b0, bus0.flush}, {31'b0, first});
      check("redirect_valid", {31'b0, bus0.redirect_valid}, {31'b0, first});
      check("buf_clear", {31'b0, bus0.buf_clear}, {31'b0, first});
      check("redirect_pc", bus0.redirect_pc, m_rpc);
      check("br_count", brc0, m_br);
      check("mispred_count", mc0, m_mis);
      check("state", 32'(st0), 32'(exp_st));
      if (run) begin
         check("buf_empty", {31'b0, bus0.buf_empty}, {31'b0, exp_q.size() == 0});
         if (exp_q.size() > 0) check("buf_head", bus0.buf_head, exp_q[0]);
      end
      @(posedge clk);
      if (busy > 0) busy--;
      if (pop_ok) begin
         void'(exp_q.pop_front());
         m_br++;
      end
      if (mis) begin
         m_mis++;
         m_rpc = bpc;
         busy  = FH0 + 1;
         exp_q.delete();
      end
      if (push_ok) exp_q.push_back(ppc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] bpc, ppc;
      bus0.pred_valid = 1'b0; bus0.pred_pc = '0; bus0.br_valid = 1'b0; bus0.br_actual_pc = '0;
      bus1.pred_valid = 1'b0; bus1.pred_pc = '0; bus1.br_valid = 1'b0; bus1.br_actual_pc = '0;
      model_reset();
      repeat (3) @(posedge clk);

      // Reset state, then two correct predictions.
      idle(1);
      step(1'b1, 32'h100, 1'b0, 32'h0);
      step(1'b1, 32'h200, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b1, 32'h100);
      step(1'b0, 32'h0, 1'b1, 32'h200);
      idle(1);
      #1;
      check("tp1_br_count", brc0, 32'd2);
      check("tp1_mispred", mc0, 32'd0);

      // Single mispredict with the full flush/hold sequence.
      step(1'b1, 32'h100, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b1, 32'h104);
      idle(4);
      #1;
      check("tp2_redirect_pc", bus0.redirect_pc, 32'h104);
      check("tp2_mispred", mc0, 32'd1);

      // Fill to 16, then pop with a concurrent push offer.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0);
      step(1'b1, 32'h9990, 1'b1, 32'h1000);
      idle(1);
      for (int i = 1; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i * 4));

      // Mispredict with a push offered in the same cycle.
      step(1'b1, 32'h300, 1'b0, 32'h0);
      step(1'b1, 32'h400, 1'b1, 32'h308);
      idle(4);

      // Reset asserted during HOLD.
      step(1'b1, 32'h500, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b1, 32'h504);
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      bus0.pred_valid = 1'b0;
      bus0.br_valid   = 1'b0;
      @(posedge clk);
      model_reset();
      step(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      check("rst_hold_ready", {31'b0, bus0.pred_ready}, 32'd1);
      check("rst_hold_brc", brc0, 32'd0);

      // Zero-length hold on the second instance.
      @(negedge clk);
      bus1.pred_valid = 1'b1; bus1.pred_pc = 32'h40;
      #1;
      check("fh0_push", {31'b0, bus1.buf_enqueue}, 32'd1);
      @(negedge clk);
      bus1.pred_valid = 1'b0; bus1.br_valid = 1'b1; bus1.br_actual_pc = 32'h44;
      #1;
      check("fh0_pop", {31'b0, bus1.buf_dequeue}, 32'd1);
      check("fh0_mis_ready", {31'b0, bus1.pred_ready}, 32'd0);
      @(negedge clk);
      bus1.br_valid = 1'b0;
      #1;
      check("fh0_flush", {31'b0, bus1.flush}, 32'd1);
      check("fh0_redirect", bus1.redirect_pc, 32'h44);
      @(negedge clk);
      #1;
      check("fh0_ready_after", {31'b0, bus1.pred_ready}, 32'd1);
      check("fh0_flush_low", {31'b0, bus1.flush}, 32'd0);
      check("fh0_mispred", mc1, 32'd1);
      check("fh0_empty", {31'b0, bus1.buf_empty}, 32'd1);

      // Random traffic: mostly correct commits, occasional mispredicts.
      for (int i = 0; i < 600; i++) begin
         ppc = $urandom() & 32'hffff_fffc;
         if (exp_q.size() > 0 && $urandom_range(0, 9) != 0) bpc = exp_q[0];
         else bpc = $urandom() & 32'hffff_fffc;
         step(1'($urandom_range(0, 1)), ppc, 1'($urandom_range(0, 2) == 0), bpc);
      end
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
